// File: rtl/seq_pkg.sv
// seq_pkg: types and constants shared by the serializer and the 1101 detector
package seq_pkg;
  typedef enum logic {IDLE, SHIFT} ser_state_t;
  localparam int SEQ_WORD_W = 16;
  localparam logic [3:0] SEQ_PATTERN = 4'b1101;
endpackage

// File: rtl/seq_bit_index.sv
// seq_bit_index: loadable down-counter tracking the bit position within a word
module seq_bit_index #(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  output logic [IDX_W-1:0] idx,
  output logic             is_zero
);
  // a load wins over a decrement so a back-to-back word restarts at the MSB
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idx <= '0;
    else if (load) idx <= IDX_W'(WIDTH - 1);
    else if (dec) idx <= idx - 1'b1;
  assign is_zero = idx == '0;
endmodule

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: MSB-first parallel-to-serial stage with valid/ready on both sides
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH  = SEQ_WORD_W,
  parameter int IDX_W  = $clog2(WIDTH),
  parameter int WCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [WIDTH-1:0]  load_data,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              bit_out,
  output logic              bit_last,
  output logic              busy,
  output logic [WCNT_W-1:0] word_count
);
  ser_state_t state;
  logic [WIDTH-1:0] sr;
  logic [IDX_W-1:0] idx;
  logic is_zero, beat, load_acc, last_beat;
  assign bit_valid = state == SHIFT;
  assign busy = state == SHIFT;
  assign bit_out = sr[WIDTH-1];
  assign bit_last = (state == SHIFT) & is_zero;
  assign beat = bit_valid & bit_ready;
  assign last_beat = beat & is_zero;
  assign load_ready = (state == IDLE) | last_beat;
  assign load_acc = load_valid & load_ready;
  seq_bit_index #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_idx (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load_acc),
    .dec    (beat),
    .idx    (idx),
    .is_zero(is_zero)
  );
  // word capture, shifting, state sequencing and completed-word counting
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sr <= '0;
      word_count <= '0;
    end else begin
      state <= load_acc ? SHIFT : last_beat ? IDLE : state;
      sr <= load_acc ? load_data : beat ? sr << 1 : sr;
      word_count <= word_count + WCNT_W'(last_beat);
    end
endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer: randomized scoreboard bench for the bit serializer
module tb_seq_bit_serializer;
  logic clk = 0, rst_n = 0, load_valid = 0, bit_ready = 1;
  logic [15:0] load_data = '0;
  logic load_ready, bit_valid, bit_out, bit_last, busy;
  logic [7:0] word_count;
  logic [1:0] exp_q[$];
  logic [7:0] exp_wc = 0;
  int compared = 0, mismatched = 0, words_done = 0, rdy_mode = 0;

  seq_bit_serializer dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .bit_out(bit_out), .bit_last(bit_last), .busy(busy), .word_count(word_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d at %0t", n, act, exp, $time);
    end
  endfunction

  // ready pattern: 0 always ready, 1 random back-pressure, 2 driven by a test
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) bit_ready = 1;
    else if (rdy_mode == 1) bit_ready = $urandom_range(0, 3) != 0;
  end

  // monitor: the queue holds {bit, last} of every accepted word not yet emitted
  always @(negedge clk) if (rst_n) begin
    chk("bit_valid", bit_valid, exp_q.size() != 0);
    chk("busy", busy, exp_q.size() != 0);
    chk("load_ready", load_ready, exp_q.size() == 0 || (exp_q.size() == 1 && bit_ready));
    chk("word_count", word_count, exp_wc);
    if (bit_valid && exp_q.size() != 0) begin
      chk("bit_out", bit_out, exp_q[0][1]);
      chk("bit_last", bit_last, exp_q[0][0]);
    end
    if (bit_valid && bit_ready) begin
      if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        if (exp_q[0][0]) exp_wc++;
        void'(exp_q.pop_front());
      end
    end
    if (load_valid && load_ready)
      for (int i = 15; i >= 0; i--) exp_q.push_back({load_data[i], i == 0});
  end

  task automatic load_word(input logic [15:0] d);
    bit acc = 0;
    int n = 0;
    load_valid = 1;
    load_data = d;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = load_ready;
      n++;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("load_timeout", 0, 1);
    else words_done++;
    load_valid = 0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      done = !bit_valid && exp_q.size() == 0;
    end
    if (!done) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1;
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_bit_out", bit_out, 0);
    chk("rst_bit_last", bit_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_word_count", word_count, 0);
    cycles(2);
    rst_n = 1;
    cycles(1);
    // basic word at full rate
    load_word(16'hDB6D);
    wait_idle();
    chk("basic_count", word_count, 1);
    // back-pressure: three-cycle stalls before beats 0, 7 and 15
    rdy_mode = 2;
    load_word(16'hA5F0);
    for (int k = 0; k < 16; k++) begin
      if (k == 0 || k == 7 || k == 15) begin
        bit_ready = 0;
        cycles(3);
      end
      bit_ready = 1;
      cycles(1);
    end
    rdy_mode = 0;
    wait_idle();
    // back-to-back words with no gap
    load_word(16'hDB6D);
    load_word(16'h0000);
    wait_idle();
    chk("b2b_count", word_count, 4);
    // load attempt in the middle of a word must be ignored
    load_word(16'h1234);
    cycles(4);
    load_valid = 1;
    load_data = 16'hFFFF;
    cycles(3);
    load_valid = 0;
    wait_idle();
    chk("illegal_count", word_count, 5);
    // randomized words with random back-pressure and gaps
    rdy_mode = 1;
    for (int w = 0; w < 40; w++) begin
      load_word(16'($urandom));
      cycles($urandom_range(0, 3));
    end
    rdy_mode = 0;
    wait_idle();
    chk("random_count", word_count, words_done % 256);
    // asynchronous reset mid-word
    load_word(16'hDB6D);
    cycles(5);
    #2;
    rst_n = 0;
    #1;
    chk("arst_bit_valid", bit_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_word_count", word_count, 0);
    exp_q.delete();
    exp_wc = 0;
    words_done = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    cycles(1);
    load_word(16'h8001);
    wait_idle();
    chk("post_rst_count", word_count, 1);
    // 256 more words wrap the counter back to the same value
    for (int w = 0; w < 256; w++) load_word(16'($urandom));
    wait_idle();
    chk("wrap_count", word_count, words_done % 256);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
